// File: rtl/ddr_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of a single DDR read port.
// One read is outstanding at a time; a read that never completes is closed by a wait-cycle timeout.
module ddr_rd_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              rsp0,
    output logic              rsp1,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              ddr_rd,
    output logic [ADDR_W-1:0] readAdd,
    input  logic              ddr_rd_valid,
    input  logic              ddr_rd_done,
    input  logic [DATA_W-1:0] ddr_rd_data,
    output logic              busy,
    output logic              timeout_sticky
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        grantId;
    logic        lastGrant;
    logic [15:0] waitCnt;
    logic        pick;
    logic        complete;

    // Under contention the requester not served last wins; otherwise the lone requester wins.
    assign pick     = (req0 && req1) ? ~lastGrant : ~req0;
    assign complete = ddr_rd_valid && ddr_rd_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            grantId        <= 1'b0;
            lastGrant      <= 1'b1;
            waitCnt        <= '0;
            ddr_rd         <= 1'b0;
            readAdd        <= '0;
            rsp0           <= 1'b0;
            rsp1           <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            busy           <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            ddr_rd  <= 1'b0;
            rsp0    <= 1'b0;
            rsp1    <= 1'b0;
            rsp_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grantId <= pick;
                        readAdd <= pick ? addr1 : addr0;
                        ddr_rd  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    waitCnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Completion is tested first so it wins over a coincident timeout.
                    if (complete) begin
                        rsp_data <= ddr_rd_data;
                        rsp0     <= ~grantId;
                        rsp1     <= grantId;
                        state    <= RESP;
                    end else if (waitCnt == WAIT_LAST) begin
                        rsp_data       <= '0;
                        rsp_err        <= 1'b1;
                        timeout_sticky <= 1'b1;
                        rsp0           <= ~grantId;
                        rsp1           <= grantId;
                        state          <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                RESP: begin
                    lastGrant <= grantId;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Scoreboard bench for ddr_rd_arbiter: a transaction-level arbitration model queues expected
// responses while a monitor compares every rsp pulse against the head of the queue.
module tb_ddr_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 512;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic          rsp0, rsp1, rsp_err, ddr_rd, busy, timeout_sticky;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] readAdd;
    logic          ddrValid = 1'b0;
    logic          ddrDone = 1'b0;
    logic [DW-1:0] ddrData = '0;

    always #5 clk = ~clk;

    ddr_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .addr0(addr0),
        .req1(req1),
        .addr1(addr1),
        .rsp0(rsp0),
        .rsp1(rsp1),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .ddr_rd(ddr_rd),
        .readAdd(readAdd),
        .ddr_rd_valid(ddrValid),
        .ddr_rd_done(ddrDone),
        .ddr_rd_data(ddrData),
        .busy(busy),
        .timeout_sticky(timeout_sticky)
    );

    typedef struct {
        logic          id;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expQ[$];
    int            errors = 0;
    int            checks = 0;
    bit            monEn = 0;
    logic          mLast = 1'b1;
    logic          mSticky = 1'b0;
    logic [DW-1:0] mData = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] randBeat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (monEn) begin
            if (rsp0 || rsp1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp0=%0d rsp1=%0d expected no response", rsp0, rsp1);
                end else begin
                    e = expQ.pop_front();
                    check("rsp0", rsp0, e.id == 1'b0);
                    check("rsp1", rsp1, e.id == 1'b1);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_data", rsp_data, e.data);
                    $display("rsp id=%0d err=%0d data_lo=%08h", e.id, rsp_err, rsp_data[31:0]);
                end
            end else begin
                check("rsp_err_idle", rsp_err, 1'b0);
            end
        end
    end

    // One arbitration round: requests are raised, the DDR side is played, and the expected
    // response comes from the round-robin rule applied to the request levels the bench drives.
    task automatic round(input bit want0, input bit want1, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input int kDone, input bit dropEarly,
                         input bit noiseAll, input logic [DW-1:0] beat);
        exp_t e;
        logic w;
        int   n;
        if (want0 && !req0) begin addr0 = a0; req0 = 1'b1; end
        if (want1 && !req1) begin addr1 = a1; req1 = 1'b1; end
        w      = (req0 && req1) ? !mLast : !req0;
        e.id   = w;
        e.err  = (kDone > TO - 1);
        e.data = e.err ? '0 : beat;
        expQ.push_back(e);
        mLast = w;

        n = 0;
        while (!ddr_rd && n < 4) begin @(negedge clk); n++; end
        check("ddr_rd_issue", ddr_rd, 1'b1);
        check("issue_latency", n <= 2, 1'b1);
        check("readAdd", readAdd, w ? addr1 : addr0);
        check("busy_issue", busy, 1'b1);
        check("rsp_data_hold", rsp_data, mData);

        @(negedge clk);
        check("ddr_rd_one_cycle", ddr_rd, 1'b0);
        if (dropEarly) begin
            if (w) req1 = 1'b0; else req0 = 1'b0;
        end
        for (int k = 0; k < TO; k++) begin
            if (k == kDone) begin
                ddrValid = 1'b1; ddrDone = 1'b1; ddrData = beat;
            end else if (noiseAll || $urandom_range(0, 2) == 0) begin
                ddrValid = 1'b1; ddrDone = 1'b0; ddrData = randBeat();
            end else begin
                ddrValid = 1'b0; ddrDone = 1'($urandom_range(0, 1)); ddrData = randBeat();
            end
            @(negedge clk);
            if (k == kDone) break;
        end
        ddrValid = 1'b0;
        ddrDone  = 1'b0;

        check("rsp_timing", rsp0 || rsp1, 1'b1);
        n = 0;
        while (!(rsp0 || rsp1) && n < 4) begin @(negedge clk); n++; end
        mSticky = mSticky | e.err;
        check("timeout_sticky", timeout_sticky, mSticky);
        check("busy_resp", busy, 1'b1);
        mData = e.data;
        if (w) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w0, w1, drop;
        int k, n;
        repeat (3) @(negedge clk);
        check("rst_rsp0", rsp0, 1'b0);
        check("rst_rsp1", rsp1, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ddr_rd", ddr_rd, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_readAdd", readAdd, '0);
        check("rst_sticky", timeout_sticky, 1'b0);
        rst   = 1'b0;
        monEn = 1;

        // Both requesters held from reset: grants must alternate starting with requester 0.
        for (int i = 0; i < 4; i++)
            round(1, 1, 32'h1000_0040, 32'h2000_0080, $urandom_range(0, 3), 0, 0, randBeat());
        while (req0 || req1) round(0, 0, '0, '0, 0, 0, 0, randBeat());

        round(1, 0, 32'h0000_0400, '0, 0, 0, 0, {(DW/8){8'hA5}});
        round(0, 1, '0, 32'h0000_2000, TO + 3, 0, 0, randBeat());
        round(0, 1, '0, 32'h0000_2040, TO - 1, 0, 0, randBeat());
        round(1, 0, 32'h0000_3000, '0, 3, 0, 1, randBeat());

        for (int i = 0; i < 40; i++) begin
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            if (!req0 && !req1 && !w0 && !w1) w0 = 1;
            k    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 2)) : int'($urandom_range(0, 2));
            drop = ($urandom_range(0, 3) == 0);
            round(w0, w1, $urandom, $urandom, k, drop, 0, randBeat());
        end
        while (req0 || req1) round(0, 0, '0, '0, 0, 0, 0, randBeat());

        // Reset in the middle of WAIT, followed by a stray completion that must be ignored.
        @(negedge clk);
        addr0 = 32'h0000_5000;
        req0  = 1'b1;
        n = 0;
        while (!ddr_rd && n < 4) begin @(negedge clk); n++; end
        check("rst_test_issue", ddr_rd, 1'b1);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        req0 = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_readAdd", readAdd, '0);
        @(negedge clk);
        rst     = 1'b0;
        mLast   = 1'b1;
        mSticky = 1'b0;
        mData   = '0;
        ddrValid = 1'b1; ddrDone = 1'b1; ddrData = randBeat();
        repeat (2) @(negedge clk);
        ddrValid = 1'b0; ddrDone = 1'b0;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_sticky", timeout_sticky, 1'b0);
        check("post_rst_rsp_data", rsp_data, '0);
        check("post_rst_ddr_rd", ddr_rd, 1'b0);
        round(1, 0, 32'h0000_6000, '0, 1, 0, 0, randBeat());

        repeat (3) @(negedge clk);
        check("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
